// File: rtl/fd_pipe_reg_if.sv
// IF/ID boundary bus: control and fetch inputs from the fetch side and the
// registered decode-side outputs.
//   master : hazard unit / fetch stage side (drives stall/flush/req and fetch data)
//   slave  : the IF/ID register itself (drives the registered outputs)
interface fd_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int EXC_W  = 5,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              flush;
    logic              req;
    logic [DATA_W-1:0] instr_in;
    logic [DATA_W-1:0] pc_in;
    logic              bd_in;
    logic [DATA_W-1:0] instr_out;
    logic [DATA_W-1:0] pc_out;
    logic              bd_out;
    logic [EXC_W-1:0]  exc_out;
    logic              valid_out;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output stall, flush, req, instr_in, pc_in, bd_in,
        input  instr_out, pc_out, bd_out, exc_out, valid_out, stall_cnt, flush_cnt
    );

    modport slave (
        input  stall, flush, req, instr_in, pc_in, bd_in,
        output instr_out, pc_out, bd_out, exc_out, valid_out, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/fd_pipe_reg.sv
// IF/ID pipeline boundary register.
// Captures fetched instruction, PC, delay-slot flag and fetch exception code.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - synchronous active-high reset
//   bus   - fd_pipe_reg_if.slave: stall/flush/req, fetch inputs, registered
//           outputs, saturating stall/flush debug counters
// Priority per edge: reset > req > stall > flush > load.
module fd_pipe_reg #(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] PC_RESET   = 32'h0000_3000,
    parameter logic [DATA_W-1:0] PC_HANDLER = 32'h0000_4180,
    parameter logic [DATA_W-1:0] NOP_INSTR  = 32'h0000_0000,
    parameter logic [DATA_W-1:0] IM_BASE    = 32'h0000_3000,
    parameter logic [DATA_W-1:0] IM_TOP     = 32'h0000_6FFF,
    parameter int                EXC_W      = 5,
    parameter logic [EXC_W-1:0]  EXC_ADEL   = 5'd4,
    parameter int                CNT_W      = 16
) (
    input  logic         clk,
    input  logic         reset,
    fd_pipe_reg_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              bd_q, bd_d;
    logic [EXC_W-1:0]  exc_q, exc_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic fetch_err;

    // Misaligned or outside the instruction memory window (unsigned compare).
    assign fetch_err = (bus.pc_in[1:0] != 2'b00) ||
                       (bus.pc_in < IM_BASE)     ||
                       (bus.pc_in > IM_TOP);

    always_comb begin
        instr_d     = instr_q;
        pc_d        = pc_q;
        bd_d        = bd_q;
        exc_d       = exc_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (bus.req) begin
            instr_d = NOP_INSTR;
            pc_d    = PC_HANDLER;
            bd_d    = 1'b0;
            exc_d   = '0;
            valid_d = 1'b0;
        end else if (bus.stall) begin
            // Hold everything; a simultaneous flush is dropped and will be
            // reasserted by the hazard unit once the stall clears.
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
        end else if (bus.flush) begin
            // Keep the fetch PC in the bubble so a later EPC stays meaningful.
            instr_d = NOP_INSTR;
            pc_d    = bus.pc_in;
            bd_d    = 1'b0;
            exc_d   = '0;
            valid_d = 1'b0;
            if (flush_cnt_q != {CNT_W{1'b1}}) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end
        end else begin
            pc_d    = bus.pc_in;
            bd_d    = bus.bd_in;
            valid_d = 1'b1;
            if (fetch_err) begin
                exc_d   = EXC_ADEL;
                instr_d = NOP_INSTR;
            end else begin
                exc_d   = '0;
                instr_d = bus.instr_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q     <= NOP_INSTR;
            pc_q        <= PC_RESET;
            bd_q        <= 1'b0;
            exc_q       <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            bd_q        <= bd_d;
            exc_q       <= exc_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.instr_out = instr_q;
    assign bus.pc_out    = pc_q;
    assign bus.bd_out    = bd_q;
    assign bus.exc_out   = exc_q;
    assign bus.valid_out = valid_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fd_pipe_reg.sv
module tb_fd_pipe_reg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic        valid;
        logic [15:0] scnt;
        logic [15:0] fcnt;
    } exp_t;

    logic clk;
    logic rst1;
    logic rst2;

    int tests  = 0;
    int failed = 0;

    exp_t sb_q[$];

    fd_pipe_reg_if #(.DATA_W(32), .EXC_W(5), .CNT_W(16)) bus1 ();
    fd_pipe_reg_if #(.DATA_W(32), .EXC_W(5), .CNT_W(2))  bus2 ();

    fd_pipe_reg #(.CNT_W(16)) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (bus1.slave)
    );

    fd_pipe_reg #(.CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (rst2),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic bd, input logic [4:0] exc, input logic valid,
                                input logic [15:0] scnt, input logic [15:0] fcnt);
        exp_t e;
        e.instr = instr; e.pc = pc; e.bd = bd; e.exc = exc;
        e.valid = valid; e.scnt = scnt; e.fcnt = fcnt;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus on the selected DUT, push its expected
    // result, then pop and compare after the edge.
    task automatic step(input string name, input bit sel, input logic rst,
                        input logic st, input logic fl, input logic rq,
                        input logic [31:0] instr, input logic [31:0] pc,
                        input logic bd, input exp_t e);
        exp_t x;
        logic [31:0] o_instr, o_pc;
        logic        o_bd, o_valid;
        logic [4:0]  o_exc;
        logic [15:0] o_scnt, o_fcnt;
        @(negedge clk);
        if (!sel) begin
            rst1 = rst; bus1.stall = st; bus1.flush = fl; bus1.req = rq;
            bus1.instr_in = instr; bus1.pc_in = pc; bus1.bd_in = bd;
        end else begin
            rst2 = rst; bus2.stall = st; bus2.flush = fl; bus2.req = rq;
            bus2.instr_in = instr; bus2.pc_in = pc; bus2.bd_in = bd;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (!sel) begin
            o_instr = bus1.instr_out; o_pc = bus1.pc_out; o_bd = bus1.bd_out;
            o_exc = bus1.exc_out; o_valid = bus1.valid_out;
            o_scnt = bus1.stall_cnt; o_fcnt = bus1.flush_cnt;
        end else begin
            o_instr = bus2.instr_out; o_pc = bus2.pc_out; o_bd = bus2.bd_out;
            o_exc = bus2.exc_out; o_valid = bus2.valid_out;
            o_scnt = {14'd0, bus2.stall_cnt}; o_fcnt = {14'd0, bus2.flush_cnt};
        end
        tests++;
        assert (sb_q.size() > 0) else begin
            failed++;
            $error("FAIL %s.queue: observed empty expected entry", name);
        end
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            chk({name, ".instr"}, o_instr, x.instr);
            chk({name, ".pc"},    o_pc,    x.pc);
            chk({name, ".bd"},    {31'd0, o_bd},    {31'd0, x.bd});
            chk({name, ".exc"},   {27'd0, o_exc},   {27'd0, x.exc});
            chk({name, ".valid"}, {31'd0, o_valid}, {31'd0, x.valid});
            chk({name, ".scnt"},  {16'd0, o_scnt},  {16'd0, x.scnt});
            chk({name, ".fcnt"},  {16'd0, o_fcnt},  {16'd0, x.fcnt});
        end
    endtask

    initial begin
        rst1 = 1'b1; rst2 = 1'b1;
        bus1.stall = 0; bus1.flush = 0; bus1.req = 0;
        bus1.instr_in = '0; bus1.pc_in = '0; bus1.bd_in = 0;
        bus2.stall = 0; bus2.flush = 0; bus2.req = 0;
        bus2.instr_in = '0; bus2.pc_in = '0; bus2.bd_in = 0;

        //        name        sel rst st fl rq instr          pc             bd  expected
        step("reset",       0, 1, 0, 0, 0, 32'hDEAD_BEEF, 32'h0000_3000, 1, mk(32'h0, 32'h3000, 0, 0, 0, 0, 0));
        step("load0",       0, 0, 0, 0, 0, 32'h2401_0005, 32'h0000_3000, 0, mk(32'h2401_0005, 32'h3000, 0, 0, 1, 0, 0));
        step("load1",       0, 0, 0, 0, 0, 32'h8C22_0000, 32'h0000_3004, 1, mk(32'h8C22_0000, 32'h3004, 1, 0, 1, 0, 0));
        step("stall1",      0, 0, 1, 0, 0, 32'h1111_0001, 32'h0000_3008, 0, mk(32'h8C22_0000, 32'h3004, 1, 0, 1, 1, 0));
        step("stall2",      0, 0, 1, 0, 0, 32'h1111_0002, 32'h0000_7000, 0, mk(32'h8C22_0000, 32'h3004, 1, 0, 1, 2, 0));
        step("stall3",      0, 0, 1, 0, 0, 32'h1111_0003, 32'h0000_300C, 0, mk(32'h8C22_0000, 32'h3004, 1, 0, 1, 3, 0));
        step("flush",       0, 0, 0, 1, 0, 32'h2222_2222, 32'h0000_3010, 1, mk(32'h0, 32'h3010, 0, 0, 0, 3, 1));
        step("req_all",     0, 0, 1, 1, 1, 32'h3333_3333, 32'h0000_3014, 1, mk(32'h0, 32'h4180, 0, 0, 0, 3, 1));
        step("stall_flush", 0, 0, 1, 1, 0, 32'h4444_4444, 32'h0000_3018, 1, mk(32'h0, 32'h4180, 0, 0, 0, 4, 1));
        step("adel_align",  0, 0, 0, 0, 0, 32'h5555_5555, 32'h0000_3002, 0, mk(32'h0, 32'h3002, 0, 4, 1, 4, 1));
        step("adel_top",    0, 0, 0, 0, 0, 32'h6666_6666, 32'h0000_7000, 1, mk(32'h0, 32'h7000, 1, 4, 1, 4, 1));
        step("top_ok",      0, 0, 0, 0, 0, 32'h1111_1111, 32'h0000_6FFC, 0, mk(32'h1111_1111, 32'h6FFC, 0, 0, 1, 4, 1));
        step("adel_base",   0, 0, 0, 0, 0, 32'h7777_7777, 32'h0000_2FFC, 0, mk(32'h0, 32'h2FFC, 0, 4, 1, 4, 1));
        step("rst_flush",   0, 1, 0, 1, 0, 32'h8888_8888, 32'h0000_3020, 1, mk(32'h0, 32'h3000, 0, 0, 0, 0, 0));
        step("post_rst",    0, 0, 0, 0, 0, 32'h0123_4567, 32'h0000_3100, 1, mk(32'h0123_4567, 32'h3100, 1, 0, 1, 0, 0));

        step("c2_reset",    1, 1, 0, 0, 0, 32'h0, 32'h0000_3000, 0, mk(32'h0, 32'h3000, 0, 0, 0, 0, 0));
        step("c2_stall1",   1, 0, 1, 0, 0, 32'hAAAA_0001, 32'h0000_3004, 1, mk(32'h0, 32'h3000, 0, 0, 0, 1, 0));
        step("c2_stall2",   1, 0, 1, 0, 0, 32'hAAAA_0002, 32'h0000_3008, 1, mk(32'h0, 32'h3000, 0, 0, 0, 2, 0));
        step("c2_stall3",   1, 0, 1, 0, 0, 32'hAAAA_0003, 32'h0000_300C, 1, mk(32'h0, 32'h3000, 0, 0, 0, 3, 0));
        step("c2_stall4",   1, 0, 1, 0, 0, 32'hAAAA_0004, 32'h0000_3010, 1, mk(32'h0, 32'h3000, 0, 0, 0, 3, 0));
        step("c2_stall5",   1, 0, 1, 0, 0, 32'hAAAA_0005, 32'h0000_3014, 1, mk(32'h0, 32'h3000, 0, 0, 0, 3, 0));
        step("c2_stall6",   1, 0, 1, 0, 0, 32'hAAAA_0006, 32'h0000_3018, 1, mk(32'h0, 32'h3000, 0, 0, 0, 3, 0));
        step("c2_rst_stall",1, 1, 1, 0, 0, 32'hAAAA_0007, 32'h0000_301C, 1, mk(32'h0, 32'h3000, 0, 0, 0, 0, 0));
        step("c2_load",     1, 0, 0, 0, 0, 32'hBBBB_BBBB, 32'h0000_3020, 0, mk(32'hBBBB_BBBB, 32'h3020, 0, 0, 1, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
